// File: rtl/multi_channel_serializer.sv
// Parallel-to-serial frame sender: captures an NCH-bit word and emits one channel bit per slot,
// each slot lasting DIV clocks, with zero-gap chaining of back-to-back words.
module multi_channel_serializer #(
    parameter int unsigned NCH       = 2,
    parameter int unsigned DIV       = 2,
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [NCH-1:0] in_data,
    output logic           data,
    output logic           data_valid,
    output logic           frame_start,
    output logic           busy
);
    localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NCH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [SW-1:0]  slot_q, slot_d;
    logic [NCH-1:0] shreg_q, shreg_d;
    logic           data_q, data_d;
    logic           valid_q, valid_d;
    logic           start_q, start_d;

    logic last_tick, last_slot, frame_end, accept;
    logic first_bit, next_bit;
    logic [NCH-1:0] shifted;

    assign last_tick = (tick_q == TICK_LAST);
    assign last_slot = (slot_q == SLOT_LAST);
    assign frame_end = (state_q == StShift) && last_tick && last_slot;
    assign in_ready  = (state_q == StIdle) || frame_end;
    assign accept    = in_valid && in_ready;

    // The head of the shift register is always the bit currently on data; the next bit sits
    // one position further along in the sending direction.
    assign first_bit = (LSB_FIRST != 0) ? in_data[0] : in_data[NCH-1];
    assign next_bit  = (LSB_FIRST != 0) ? shreg_q[1] : shreg_q[NCH-2];
    assign shifted   = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        slot_d  = slot_q;
        shreg_d = shreg_q;
        data_d  = 1'b0;
        valid_d = 1'b0;
        start_d = 1'b0;
        if (accept) begin
            state_d = StShift;
            tick_d  = '0;
            slot_d  = '0;
            shreg_d = in_data;
            data_d  = first_bit;
            valid_d = 1'b1;
            start_d = 1'b1;
        end else if (state_q == StShift) begin
            if (frame_end) begin
                state_d = StIdle;
                tick_d  = '0;
                slot_d  = '0;
                shreg_d = '0;
            end else if (last_tick) begin
                tick_d  = '0;
                slot_d  = slot_q + SW'(1);
                shreg_d = shifted;
                data_d  = next_bit;
                valid_d = 1'b1;
            end else begin
                tick_d  = tick_q + TW'(1);
                data_d  = data_q;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            tick_q  <= '0;
            slot_q  <= '0;
            shreg_q <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            slot_q  <= slot_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            start_q <= start_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = valid_q;
    assign frame_start = start_q;
    assign busy        = (state_q == StShift);

endmodule

// File: tb/tb_multi_channel_serializer.sv
// Bench for multi_channel_serializer: four differently-parameterised instances checked every
// cycle against a frame-position model, plus directed traces with hand-computed expectations.
module tb_multi_channel_serializer;
    localparam int NCH_T[4] = '{4, 4, 2, 2};
    localparam int DIV_T[4] = '{2, 2, 1, 2};
    localparam int LSB_T[4] = '{1, 0, 1, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] vld;
    logic [3:0] din [4];
    logic [3:0] rdy, dat, dv, fs, bsy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_channel_serializer #(.NCH(4), .DIV(2), .LSB_FIRST(1)) u_lsb (
        .clk(clk), .reset(rst), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(din[0]),
        .data(dat[0]), .data_valid(dv[0]), .frame_start(fs[0]), .busy(bsy[0]));
    multi_channel_serializer #(.NCH(4), .DIV(2), .LSB_FIRST(0)) u_msb (
        .clk(clk), .reset(rst), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(din[1]),
        .data(dat[1]), .data_valid(dv[1]), .frame_start(fs[1]), .busy(bsy[1]));
    multi_channel_serializer #(.NCH(2), .DIV(1), .LSB_FIRST(1)) u_d1 (
        .clk(clk), .reset(rst), .in_valid(vld[2]), .in_ready(rdy[2]), .in_data(din[2][1:0]),
        .data(dat[2]), .data_valid(dv[2]), .frame_start(fs[2]), .busy(bsy[2]));
    multi_channel_serializer #(.NCH(2), .DIV(2), .LSB_FIRST(1)) u_def (
        .clk(clk), .reset(rst), .in_valid(vld[3]), .in_ready(rdy[3]), .in_data(din[3][1:0]),
        .data(dat[3]), .data_valid(dv[3]), .frame_start(fs[3]), .busy(bsy[3]));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    // Model: pos = cycle index inside the frame being output (-1 when idle).
    int         pos [4] = '{-1, -1, -1, -1};
    logic [3:0] word [4];
    logic       started = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                pos[k] <= -1;
            end else if (vld[k] && (pos[k] < 0 || pos[k] == NCH_T[k] * DIV_T[k] - 1)) begin
                pos[k]  <= 0;
                word[k] <= din[k];
            end else if (pos[k] >= 0) begin
                pos[k] <= (pos[k] == NCH_T[k] * DIV_T[k] - 1) ? -1 : pos[k] + 1;
            end
        end
        if (rst) started <= 1'b1;
    end

    always @(negedge clk) begin
        logic [4:0] e, g;
        int idx, ch;
        if (started) begin
            for (int k = 0; k < 4; k++) begin
                if (pos[k] < 0) begin
                    e = 5'b10000;
                end else begin
                    idx = pos[k] / DIV_T[k];
                    ch  = (LSB_T[k] != 0) ? idx : NCH_T[k] - 1 - idx;
                    e   = {pos[k] == NCH_T[k] * DIV_T[k] - 1, 1'b1, pos[k] == 0, 1'b1,
                           word[k][ch]};
                end
                g = {rdy[k], bsy[k], fs[k], dv[k], dat[k]};
                chk($sformatf("model_u%0d_t%0t {rdy,busy,fs,dv,data}", k, $time), 32'(g), 32'(e));
            end
        end
    end

    logic [31:0] tr_d, tr_v, tr_f, tr_r;
    int tn;

    task automatic send(input int k, input logic [3:0] w);
        chk($sformatf("ready_before_send_u%0d", k), 32'(rdy[k]), 32'd1);
        vld[k] = 1'b1;
        din[k] = w;
        tr_d = '0; tr_v = '0; tr_f = '0; tr_r = '0; tn = 0;
    endtask

    task automatic cyc(input int k);
        @(negedge clk);
        tr_d[tn] = dat[k];
        tr_v[tn] = dv[k];
        tr_f[tn] = fs[k];
        tr_r[tn] = rdy[k];
        tn++;
    endtask

    task automatic chk_tr(input string nm, input logic [31:0] ed, input logic [31:0] ev,
                          input logic [31:0] ef, input logic [31:0] er);
        chk({nm, "_data"}, tr_d, ed);
        chk({nm, "_valid"}, tr_v, ev);
        chk({nm, "_start"}, tr_f, ef);
        chk({nm, "_ready"}, tr_r, er);
    endtask

    initial begin
        rst = 1'b1;
        vld = '0;
        for (int k = 0; k < 4; k++) din[k] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // LSB first, 1011 -> 1,1,0,1 each for 2 cycles, then idle
        send(0, 4'b1011);
        cyc(0); vld[0] = 1'b0;
        repeat (8) cyc(0);
        chk_tr("lsb", 32'hCF, 32'hFF, 32'h1, 32'h180);
        repeat (3) @(negedge clk);

        // MSB first, 1011 -> 1,0,1,1
        send(1, 4'b1011);
        cyc(1); vld[1] = 1'b0;
        repeat (8) cyc(1);
        chk_tr("msb", 32'hF3, 32'hFF, 32'h1, 32'h180);
        repeat (3) @(negedge clk);

        // Back-to-back: 1011 then 0100 chained with no gap
        send(0, 4'b1011);
        cyc(0); din[0] = 4'b0100;
        repeat (15) cyc(0);
        vld[0] = 1'b0;
        cyc(0);
        chk_tr("b2b", 32'h30CF, 32'hFFFF, 32'h101, 32'h18080);
        repeat (3) @(negedge clk);

        // Reset in the middle of a frame, then a clean restart
        send(0, 4'b1011);
        cyc(0); vld[0] = 1'b0;
        repeat (3) cyc(0);
        rst = 1'b1;
        cyc(0); rst = 1'b0;
        cyc(0); vld[0] = 1'b1; din[0] = 4'b0111;
        cyc(0); vld[0] = 1'b0;
        cyc(0);
        chk_tr("midrst", 32'hCF, 32'hCF, 32'h41, 32'h30);
        repeat (6) @(negedge clk);

        // DIV=1 streaming of alternating words; offers during non-final cycles are ignored
        send(2, 4'b0001);
        for (int i = 1; i <= 9; i++) begin
            cyc(2);
            if (i == 8) vld[2] = 1'b0;
            else if (i < 8 && (i % 2) == 1) din[2] = (din[2] == 4'b0001) ? 4'b0010 : 4'b0001;
        end
        chk_tr("div1", 32'h99, 32'hFF, 32'h55, 32'h1AA);
        repeat (3) @(negedge clk);

        // Reset pulse during a frame of the default-parameter instance
        send(3, 4'b0011);
        cyc(3); vld[3] = 1'b0;
        cyc(3); rst = 1'b1;
        cyc(3); rst = 1'b0;
        chk("rst_data", 32'(dat[3]), 32'd0);
        chk("rst_valid", 32'(dv[3]), 32'd0);
        chk("rst_start", 32'(fs[3]), 32'd0);
        chk("rst_busy", 32'(bsy[3]), 32'd0);
        chk("rst_ready", 32'(rdy[3]), 32'd1);

        // Reset wins over an acceptance in the same cycle
        vld[3] = 1'b1; din[3] = 4'b0011; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; vld[3] = 1'b0;
        chk("rstprio_busy", 32'(bsy[3]), 32'd0);
        @(negedge clk);
        chk("rstprio_valid", 32'(dv[3]), 32'd0);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_channel_serializer.md
MULTI_CHANNEL_SERIALIZER -- requirements
Module: multi_channel_serializer

Interface
- REQ-001: The block SHALL have parameter NCH, default 2, meaning the number of input channels (legal range 2..32).
- REQ-002: The block SHALL have parameter DIV, default 2, meaning clk cycles per output slot (legal range 1..256).
- REQ-003: The block SHALL have parameter LSB_FIRST, default 1: 1 means channel 0 is sent first, 0 means channel NCH-1 is sent first.
- REQ-004: The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-005: The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-006: The block SHALL have port in_valid, input, 1 bit: a parallel word is offered.
- REQ-007: The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
- REQ-008: The block SHALL have port in_data, input, NCH bits: bit i is the channel i sample.
- REQ-009: The block SHALL have port data, output, 1 bit: the registered serial output.
- REQ-010: The block SHALL have port data_valid, output, 1 bit: data carries a frame bit.
- REQ-011: The block SHALL have port frame_start, output, 1 bit: a one-cycle marker on the first cycle of slot 0.
- REQ-012: The block SHALL have port busy, output, 1 bit: the FSM is in SHIFT.

Function
- REQ-013: The block SHALL implement a two-state FSM, IDLE and SHIFT.
- REQ-014: The block SHALL contain a tick counter of width max(1,clog2(DIV)) and a slot counter of width max(1,clog2(NCH)); both are zero in IDLE.
- REQ-015: A word SHALL be accepted when in_valid and in_ready are both high in the same cycle; in_data SHALL be captured into the shift register that cycle.
- REQ-016: in_ready SHALL be high in IDLE and in the final cycle of a frame (slot=NCH-1, tick=DIV-1); it SHALL be low otherwise.
- REQ-017: Acceptance at cycle T SHALL present the first bit on data at T+1, with data_valid=1 and frame_start=1 at T+1.
- REQ-018: Each slot SHALL hold data constant for exactly DIV cycles; a frame SHALL last NCH*DIV cycles.
- REQ-019: The tick counter SHALL wrap DIV-1 to 0 and advance the slot counter; the slot counter SHALL wrap NCH-1 to 0 only on a back-to-back accept.
- REQ-020: Bit order SHALL be in_data[0..NCH-1] when LSB_FIRST=1, and in_data[NCH-1..0] when LSB_FIRST=0.
- REQ-021: On acceptance in the final frame cycle, the next frame SHALL start with zero gap: data_valid stays 1 and frame_start pulses on the following cycle.
- REQ-022: When a frame ends without acceptance, the FSM SHALL go to IDLE; data=0 and data_valid=0 on the next cycle.
- REQ-023: in_valid asserted while in_ready=0 SHALL be ignored, and in_data SHALL NOT be sampled; the sender holds the word until accepted.
- REQ-024: DIV=1 SHALL be supported, with every cycle both first and last tick of its slot.
- REQ-025: busy SHALL equal (state==SHIFT), registered.

Reset
- REQ-026: With reset high at a clock edge, the next cycle SHALL show state=IDLE, counters=0, shift register=0, data=0, data_valid=0, frame_start=0, busy=0, and in_ready=1.
- REQ-027: Reset SHALL take priority over acceptance in the same cycle; that word is not captured.
- REQ-028: Reset mid-frame SHALL discard the partial frame with no further frame bits emitted.

Verification
- REQ-029: Reset check: NCH=2, DIV=2, reset pulsed 1 cycle -> next cycle data=0, data_valid=0, frame_start=0, busy=0, in_ready=1.
- REQ-030: LSB-first frame: NCH=4, DIV=2, LSB_FIRST=1, in_data=4'b1011 accepted at T -> data=1,1,0,1, each held 2 cycles over T+1..T+8; frame_start only at T+1; in_ready=1 at T+8; data_valid=0 at T+9.
- REQ-031: MSB-first frame: same stimulus with LSB_FIRST=0 -> data=1,0,1,1.
- REQ-032: Back-to-back: in_valid held with 4'b1011, then 4'b0100 accepted at T+8 -> data_valid=1 continuously T+1..T+16; frame_start at T+1 and T+9; second frame bits 0,0,1,0.
- REQ-033: Reset mid-frame: reset at T+4 -> at T+5 data=0, data_valid=0, in_ready=1; a new word accepted at T+6 starts cleanly at T+7 with frame_start=1.
- REQ-034: Two-channel, DIV=1, NCH=2: stream alternating data1/data2 words -> data alternates channel 0, channel 1 every cycle with no gaps; ignored in_valid during the non-final cycle leaves output unchanged.
